fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Produces the `counter` and `stage_num` buses consumed by the FFT datapath mux-select decoder; it is the source end of that control interface.
- Steps a 32-point transform through three phases: sample load, compute passes, result unload.
- Handshakes with the upstream sample source and the downstream result sink.
- Issues busy/done status to the top-level controller.

Parameters:
- N_POINTS, 32, transform size in samples; load/unload phase length.
- CNT_W, 6, counter width; compute pass length = 2**CNT_W cycles.
- STAGE_W, 3, stage_num width.
- LAST_PASS, 6, highest compute stage_num; passes are 1..LAST_PASS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a transform; sampled only in IDLE.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  sequencer accepting a sample (LOAD only).
- out_ready  in  1  downstream accepting a result.
- out_valid  out  1  result presented (UNLOAD only).
- counter  out  CNT_W  intra-stage cycle index to the mux decoder.
- stage_num  out  STAGE_W  current stage to the mux decoder.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final result transfers.

Behaviour:
- Interface fixed: one clock `clk`; `rst_n` synchronous, active-low; all state updates on the rising clk edge.
- Reset values: state=IDLE, counter=0, stage_num=0, in_ready=0, out_valid=0, busy=0, done=0.
- FSM states: IDLE, LOAD, COMPUTE, UNLOAD, DONE.
- IDLE:
  - counter=0, stage_num=0.
  - start=1 -> next state LOAD; busy=1 from the following cycle.
- LOAD:
  - stage_num=0; in_ready=1.
  - counter increments only on in_valid&in_ready, counting 0..N_POINTS-1.
  - Transfer at counter=N_POINTS-1 -> counter=0, stage_num=1, state=COMPUTE.
  - in_valid=0 stalls the counter; no timeout.
- COMPUTE:
  - Free-running; counter increments every cycle 0..2**CNT_W-1 and wraps to 0.
  - Each wrap increments stage_num.
  - counter[CNT_W-1] marks the second half of a pass; the decoder relies on this. Each half is exactly 2**(CNT_W-1) cycles.
  - Wrap while stage_num=LAST_PASS -> stage_num=7, counter=0, state=UNLOAD.
- UNLOAD:
  - stage_num=7; out_valid=1.
  - counter advances only on out_valid&out_ready, counting 0..N_POINTS-1.
  - Transfer at N_POINTS-1 -> state DONE, counter=0.
- DONE:
  - done=1 for exactly one cycle.
  - busy=0, stage_num=0.
  - Next state IDLE unconditionally.
- start is ignored outside IDLE; start held high re-arms only after the pass through IDLE. Minimum 1 idle cycle between transforms.
- Outputs are registered; counter/stage_num change only on clock edges, so the decoder sees glitch-free inputs.
- stage_num never takes a value in LAST_PASS+1..6 (none with defaults).
- counter never exceeds N_POINTS-1 in LOAD/UNLOAD.
- rst_n=0 in any state, including mid-LOAD/UNLOAD handshake: abort next edge to reset values. No partial-transform completion; done is not asserted.
- Simultaneous in_valid at the LOAD->COMPUTE transition edge: that transfer is the final sample. in_ready drops the next cycle.
- Total latency with no stalls: start accept -> done = 1 + N_POINTS + LAST_PASS*2**CNT_W + N_POINTS cycles (449 for defaults).

Decomposition:
- Shared package `fft_ctrl_pkg`:
  - state enum encoding.
  - STAGE_LOAD=3'd0, STAGE_UNLOAD=3'd7, LAST_PASS, N_POINTS, CNT_W, STAGE_W constants.
  - The mux decoder imports the same stage constants.
- Optional sub-module `stage_counter`: loadable, enable-gated CNT_W counter with terminal-count output, reused for the LOAD, COMPUTE and UNLOAD phases.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> all outputs 0. start=0 for 10 cycles -> state stays IDLE, counter=0.
- Full transform, no stalls: start pulse, in_valid=1, out_ready=1 ->
  - stage_num sequence 0(32 cyc), 1..6 (64 cyc each), 7(32 cyc).
  - done pulse exactly 449 cycles after the start-accept edge; busy drops with done.
- LOAD stall: in_valid toggled 1/0 each cycle -> counter advances only on transfer cycles; 64 cycles to reach stage_num=1.
- UNLOAD backpressure: out_ready=0 for 20 cycles at counter=10 -> counter holds at 10, out_valid stays 1; resumes at 11 on release.
- Reset mid-COMPUTE: rst_n=0 at stage_num=3, counter=40 -> next edge all reset values; no done pulse. Fresh start completes normally.
- start held high continuously -> back-to-back transforms, each separated by DONE+IDLE (2 cycles); start ignored while busy=1.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared control constants and state encoding for the FFT stage sequencer
// and the datapath mux-select decoder that consumes counter/stage_num.
package fft_ctrl_pkg;

   localparam int N_POINTS = 32;
   localparam int CNT_W    = 6;
   localparam int STAGE_W  = 3;

   localparam logic [STAGE_W-1:0] STAGE_LOAD   = 3'd0;
   localparam logic [STAGE_W-1:0] STAGE_UNLOAD = 3'd7;
   localparam logic [STAGE_W-1:0] LAST_PASS    = 3'd6;

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N_POINTS - 1);
   localparam logic [CNT_W-1:0] PASS_LAST = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_UNLOAD,
      S_DONE
   } seq_state_t;

   // Terminal count of the phase counter: full natural wrap during compute,
   // one transform's worth of samples during load/unload.
   function automatic logic [CNT_W-1:0] phase_last(input seq_state_t s);
      return (s == S_COMPUTE) ? PASS_LAST : LOAD_LAST;
   endfunction

endpackage

// File: rtl/stage_counter.sv
// Enable-gated phase counter with synchronous clear and a programmable
// terminal value; wraps to zero on an enabled cycle at terminal count.
module stage_counter
   import fft_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [CNT_W-1:0] last,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   assign tc = (count == last);

   // NOTE: registers are written with <= so every flop samples the
   // pre-edge values; blocking = here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Load / compute / unload sequencer for a 32-point FFT; drives the
// registered counter and stage_num buses to the datapath mux decoder.
module fft_stage_sequencer
   import fft_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [CNT_W-1:0]   counter,
   output logic [STAGE_W-1:0] stage_num,
   output logic               busy,
   output logic               done
);

   seq_state_t       state;
   logic             xfer_in;
   logic             xfer_out;
   logic             cnt_en;
   logic             cnt_tc;
   logic [CNT_W-1:0] cnt_last;

   assign xfer_in  = (state == S_LOAD)   && in_valid  && in_ready;
   assign xfer_out = (state == S_UNLOAD) && out_valid && out_ready;
   assign cnt_last = phase_last(state);

   // NOTE: cnt_en gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_en = 1'b0;
      unique case (state)
         S_LOAD:    cnt_en = xfer_in;
         S_COMPUTE: cnt_en = 1'b1;
         S_UNLOAD:  cnt_en = xfer_out;
         default:   cnt_en = 1'b0;
      endcase
   end

   stage_counter u_stage_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state == S_IDLE),
      .en    (cnt_en),
      .last  (cnt_last),
      .count (counter),
      .tc    (cnt_tc)
   );

   // Every status output is set on the edge that enters its state, so the
   // decoder and controller only ever see flop outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         stage_num <= STAGE_LOAD;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= S_LOAD;
                  stage_num <= STAGE_LOAD;
                  in_ready  <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            S_LOAD: begin
               if (xfer_in && cnt_tc) begin
                  state     <= S_COMPUTE;
                  stage_num <= STAGE_W'(1);
                  in_ready  <= 1'b0;
               end
            end
            S_COMPUTE: begin
               if (cnt_tc) begin
                  if (stage_num == LAST_PASS) begin
                     state     <= S_UNLOAD;
                     stage_num <= STAGE_UNLOAD;
                     out_valid <= 1'b1;
                  end else begin
                     stage_num <= stage_num + STAGE_W'(1);
                  end
               end
            end
            S_UNLOAD: begin
               if (xfer_out && cnt_tc) begin
                  state     <= S_DONE;
                  stage_num <= STAGE_LOAD;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               stage_num <= STAGE_LOAD;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed self-checking bench for fft_stage_sequencer: reset, full
// transform timing, load stalls, unload backpressure, abort and re-arm.
module tb_fft_stage_sequencer;
   import fft_ctrl_pkg::*;

   logic               clk       = 1'b0;
   logic               rst_n     = 1'b0;
   logic               start     = 1'b0;
   logic               in_valid  = 1'b0;
   logic               out_ready = 1'b0;
   logic               in_ready;
   logic               out_valid;
   logic [CNT_W-1:0]   counter;
   logic [STAGE_W-1:0] stage_num;
   logic               busy;
   logic               done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fft_stage_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .counter   (counter),
      .stage_num (stage_num),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   // Counts rising edges until done is seen, including the edge that
   // accepts start when called from IDLE with start already high.
   task automatic run_to_done(input int bound, output int edges);
      edges = 0;
      do begin
         tick();
         edges++;
      end while (!done && edges < bound);
   endtask

   initial begin
      int edges;
      int k;
      int es;
      int ec;
      int found;

      // Reset and idle
      tick();
      tick();
      check("rst_counter",   counter,   0);
      check("rst_stage",     stage_num, 0);
      check("rst_in_ready",  in_ready,  0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy",      busy,      0);
      check("rst_done",      done,      0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_busy",    busy,     0);
         check("idle_counter", counter,  0);
         check("idle_ready",   in_ready, 0);
      end

      // Full transform, no stalls
      in_valid  = 1'b1;
      out_ready = 1'b1;
      start     = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      k     = 0;
      while (!done && edges < 600) begin
         if (k < 32) begin
            es = 0;
            ec = k;
         end else if (k < 416) begin
            es = 1 + (k - 32) / 64;
            ec = (k - 32) % 64;
         end else begin
            es = 7;
            ec = k - 416;
         end
         check("stage_seq",     stage_num, es);
         check("counter_seq",   counter,   ec);
         check("busy_run",      busy,      1);
         check("in_ready_run",  in_ready,  (k < 32));
         check("out_valid_run", out_valid, (k >= 416 && k < 448));
         tick();
         edges++;
         k++;
      end
      check("latency_nostall", edges,     449);
      check("done_pulse",      done,      1);
      check("done_busy_low",   busy,      0);
      check("done_stage",      stage_num, 0);
      check("done_out_valid",  out_valid, 0);
      tick();
      check("done_one_cycle",  done,      0);

      // LOAD stall: in_valid alternates, starting low
      start    = 1'b1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      check("stall_accept", in_ready, 1);
      for (int j = 1; j <= 64; j++) begin
         in_valid = (j % 2 == 0);
         tick();
         if (j < 64) begin
            check("stall_counter", counter,   j / 2);
            check("stall_stage",   stage_num, 0);
         end else begin
            check("stall_stage_1",       stage_num, 1);
            check("stall_counter_wrap",  counter,   0);
            check("stall_in_ready_drop", in_ready,  0);
         end
      end
      in_valid = 1'b1;

      // UNLOAD backpressure at counter 10
      out_ready = 1'b1;
      k = 0;
      while (!out_valid && k < 500) begin
         tick();
         k++;
      end
      check("unload_reached", out_valid, 1);
      check("unload_stage",   stage_num, 7);
      check("unload_start",   counter,   0);
      for (int j = 0; j < 10; j++) tick();
      check("unload_at_10", counter, 10);
      out_ready = 1'b0;
      for (int j = 0; j < 20; j++) begin
         tick();
         check("bp_counter_hold", counter,   10);
         check("bp_out_valid",    out_valid, 1);
      end
      out_ready = 1'b1;
      tick();
      check("bp_resume", counter, 11);
      run_to_done(100, edges);
      check("bp_remaining", edges, 21);
      tick();

      // Reset mid-COMPUTE at stage 3, counter 40
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 0;
      k     = 0;
      while (found == 0 && k < 1000) begin
         if (stage_num == 3 && counter == 40) found = 1;
         else begin
            tick();
            k++;
         end
      end
      check("abort_point_found", found, 1);
      rst_n = 1'b0;
      tick();
      check("abort_counter",   counter,   0);
      check("abort_stage",     stage_num, 0);
      check("abort_in_ready",  in_ready,  0);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy",      busy,      0);
      check("abort_done",      done,      0);
      rst_n = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         check("abort_no_done", done, 0);
         check("abort_idle",    busy, 0);
      end
      start = 1'b1;
      run_to_done(1000, edges);
      start = 1'b0;
      check("fresh_latency", edges, 449);
      tick();

      // start held high: back-to-back transforms
      start = 1'b1;
      run_to_done(1000, edges);
      check("b2b_first_latency", edges, 449);
      tick();
      check("b2b_idle_busy", busy, 0);
      check("b2b_idle_done", done, 0);
      run_to_done(1000, edges);
      check("b2b_second_latency", edges, 449);
      start = 1'b0;
      tick();
      check("b2b_end_done", done, 0);
      tick();
      check("b2b_end_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
